// File: rtl/rvs_xrf_wb_arb.sv
// rtl/rvs_xrf_wb_arb.sv - XRF write-port arbiter: in-order vector write-back FIFO merged onto scalar write ports
// Scalar requests own their port unless the starvation counter has saturated.
module rvs_xrf_wb_arb #(
    parameter int NUM_RT_UOP   = 4,
    parameter int NUM_WR_PORT  = 2,
    parameter int XLEN         = 32,
    parameter int XADDR_W      = 5,
    parameter int FIFO_DEPTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RT_UOP-1:0]          rt_xrf_valid_rvv2rvs,
    input  logic [NUM_RT_UOP*XADDR_W-1:0]  rt_xrf_addr_rvv2rvs,
    input  logic [NUM_RT_UOP*XLEN-1:0]     rt_xrf_data_rvv2rvs,
    output logic [NUM_RT_UOP-1:0]          rt_xrf_ready_rvs2rvv,
    input  logic [NUM_WR_PORT-1:0]         sc_wr_valid,
    input  logic [NUM_WR_PORT*XADDR_W-1:0] sc_wr_addr,
    input  logic [NUM_WR_PORT*XLEN-1:0]    sc_wr_data,
    output logic [NUM_WR_PORT-1:0]         sc_wr_ready,
    output logic [NUM_WR_PORT-1:0]         xrf_we,
    output logic [NUM_WR_PORT*XADDR_W-1:0] xrf_waddr,
    output logic [NUM_WR_PORT*XLEN-1:0]    xrf_wdata,
    output logic                           starve_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [CW-1:0]      space;
    logic [CW-1:0]      n_push;
    logic [CW-1:0]      n_pop;
    logic [SW-1:0]      starve_cnt;
    logic               starve;
    logic [NUM_RT_UOP-1:0] push_mask;
    logic [PW-1:0]      push_idx [NUM_RT_UOP];
    logic [PW-1:0]      pop_idx;

    logic [XADDR_W-1:0] mem_addr [FIFO_DEPTH];
    logic [XLEN-1:0]    mem_data [FIFO_DEPTH];

    // Ready depends only on the registered count, never on this cycle's pops.
    always_comb begin
        space  = CW'(FIFO_DEPTH) - count;
        n_push = '0;
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            rt_xrf_ready_rvs2rvv[i] = (CW'(i) < space);
            push_mask[i]            = rt_xrf_valid_rvv2rvs[i] & rt_xrf_ready_rvs2rvv[i];
            push_idx[i]             = wr_ptr + PW'(n_push);
            n_push                  = n_push + CW'(push_mask[i]);
        end
    end

    assign starve      = (starve_cnt == SW'(STARVE_LIMIT));
    assign starve_o    = starve;
    assign sc_wr_ready = {NUM_WR_PORT{~starve}};

    // Free ports take FIFO entries in order, lowest port first, so retire order holds within a cycle.
    always_comb begin
        n_pop     = '0;
        pop_idx   = rd_ptr;
        xrf_we    = '0;
        xrf_waddr = '0;
        xrf_wdata = '0;
        for (int p = 0; p < NUM_WR_PORT; p++) begin
            if (sc_wr_valid[p] && !starve) begin
                xrf_we[p]                        = 1'b1;
                xrf_waddr[p*XADDR_W +: XADDR_W]  = sc_wr_addr[p*XADDR_W +: XADDR_W];
                xrf_wdata[p*XLEN +: XLEN]        = sc_wr_data[p*XLEN +: XLEN];
            end else if (n_pop < count) begin
                pop_idx                          = rd_ptr + PW'(n_pop);
                xrf_we[p]                        = 1'b1;
                xrf_waddr[p*XADDR_W +: XADDR_W]  = mem_addr[pop_idx];
                xrf_wdata[p*XLEN +: XLEN]        = mem_data[pop_idx];
                n_pop                            = n_pop + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_push);
            rd_ptr <= rd_ptr + PW'(n_pop);
            count  <= count + n_push - n_pop;
            if (count == '0 || n_pop != '0) begin
                starve_cnt <= '0;
            end else if (!starve) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            if (push_mask[i]) begin
                mem_addr[push_idx[i]] <= rt_xrf_addr_rvv2rvs[i*XADDR_W +: XADDR_W];
                mem_data[push_idx[i]] <= rt_xrf_data_rvv2rvs[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: tb/tb_rvs_xrf_wb_arb.sv
// tb/tb_rvs_xrf_wb_arb.sv - scoreboard bench for rvs_xrf_wb_arb with a queue-based reference model
module tb_rvs_xrf_wb_arb;
    localparam int NRT   = 4;
    localparam int NWP   = 2;
    localparam int XL    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 8;
    localparam int LIMIT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NRT-1:0]    rt_valid;
    logic [NRT*AW-1:0] rt_addr;
    logic [NRT*XL-1:0] rt_data;
    logic [NRT-1:0]    rt_ready;
    logic [NWP-1:0]    sc_valid;
    logic [NWP*AW-1:0] sc_addr;
    logic [NWP*XL-1:0] sc_data;
    logic [NWP-1:0]    sc_ready;
    logic [NWP-1:0]    xrf_we;
    logic [NWP*AW-1:0] xrf_waddr;
    logic [NWP*XL-1:0] xrf_wdata;
    logic              starve_o;

    rvs_xrf_wb_arb #(
        .NUM_RT_UOP(NRT), .NUM_WR_PORT(NWP), .XLEN(XL), .XADDR_W(AW),
        .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rt_xrf_valid_rvv2rvs(rt_valid), .rt_xrf_addr_rvv2rvs(rt_addr),
        .rt_xrf_data_rvv2rvs(rt_data), .rt_xrf_ready_rvs2rvv(rt_ready),
        .sc_wr_valid(sc_valid), .sc_wr_addr(sc_addr), .sc_wr_data(sc_data),
        .sc_wr_ready(sc_ready), .xrf_we(xrf_we), .xrf_waddr(xrf_waddr),
        .xrf_wdata(xrf_wdata), .starve_o(starve_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] a; logic [XL-1:0] d; } ent_t;
    typedef struct { int cyc; int port; logic [AW-1:0] a; logic [XL-1:0] d; } wr_t;

    ent_t mq[$];
    wr_t  expq[$];
    int   m_scnt, cyc, n_vec, n_err;

    int             st_nv;
    logic [NWP-1:0] st_scv;
    logic [AW-1:0]  st_la [NRT];
    logic [XL-1:0]  st_ld [NRT];
    logic [AW-1:0]  st_sa [NWP];
    logic [XL-1:0]  st_sd [NWP];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic set_stim(input int nv, input logic [NWP-1:0] scv);
        st_nv  = nv;
        st_scv = scv;
        for (int i = 0; i < NRT; i++) begin
            st_la[i] = AW'($urandom);
            st_ld[i] = $urandom;
        end
        for (int p = 0; p < NWP; p++) begin
            st_sa[p] = AW'($urandom);
            st_sd[p] = $urandom;
        end
    endtask

    task automatic zero_inputs();
        rt_valid = '0; rt_addr = '0; rt_data = '0;
        sc_valid = '0; sc_addr = '0; sc_data = '0;
    endtask

    // Apply one cycle of stimulus, check the handshake outputs and queue the expected writes.
    task automatic drive_cycle();
        int   n_rdy, k, sz0;
        logic st;
        logic [NRT-1:0] er;
        ent_t e;
        wr_t  w;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NRT; i++) begin
            rt_valid[i]          = (i < st_nv);
            rt_addr[i*AW +: AW]  = st_la[i];
            rt_data[i*XL +: XL]  = st_ld[i];
        end
        sc_valid = st_scv;
        for (int p = 0; p < NWP; p++) begin
            sc_addr[p*AW +: AW] = st_sa[p];
            sc_data[p*XL +: XL] = st_sd[p];
        end
        #1;
        st    = (m_scnt == LIMIT);
        n_rdy = DEPTH - mq.size();
        if (n_rdy > NRT) n_rdy = NRT;
        for (int i = 0; i < NRT; i++) er[i] = (i < n_rdy);
        chk("rt_ready", 64'(rt_ready), 64'(er));
        chk("sc_ready", 64'(sc_ready), st ? 64'(0) : 64'(2'b11));
        chk("starve_o", 64'(starve_o), 64'(st));
        sz0 = mq.size();
        k   = 0;
        for (int p = 0; p < NWP; p++) begin
            if (st_scv[p] && !st) begin
                w.cyc = cyc; w.port = p; w.a = st_sa[p]; w.d = st_sd[p];
                expq.push_back(w);
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                w.cyc = cyc; w.port = p; w.a = e.a; w.d = e.d;
                expq.push_back(w);
                k++;
            end
        end
        for (int i = 0; i < st_nv && i < n_rdy; i++) begin
            e.a = st_la[i]; e.d = st_ld[i];
            mq.push_back(e);
        end
        if (sz0 == 0 || k > 0) m_scnt = 0;
        else if (m_scnt < LIMIT) m_scnt++;
    endtask

    task automatic idle(input int n, input logic [NWP-1:0] scv);
        for (int j = 0; j < n; j++) begin
            set_stim(0, scv);
            drive_cycle();
        end
    endtask

    initial begin : monitor
        wr_t w;
        forever begin
            @(negedge clk);
            for (int p = 0; p < NWP; p++) begin
                if (xrf_we[p] === 1'b1) begin
                    if (expq.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_write cycle=%0d port=%0d actual_addr=%0d required=no_write",
                                 cyc, p, xrf_waddr[p*AW +: AW]);
                    end else begin
                        w = expq.pop_front();
                        chk("wr_cycle", 64'(cyc), 64'(w.cyc));
                        chk("wr_port",  64'(p),   64'(w.port));
                        chk("wr_addr",  64'(xrf_waddr[p*AW +: AW]), 64'(w.a));
                        chk("wr_data",  64'(xrf_wdata[p*XL +: XL]), 64'(w.d));
                    end
                end else begin
                    chk("idle_port_addr", 64'(xrf_waddr[p*AW +: AW]), 64'(0));
                    chk("idle_port_data", 64'(xrf_wdata[p*XL +: XL]), 64'(0));
                end
            end
            while (expq.size() > 0 && expq[0].cyc <= cyc) begin
                n_vec++; n_err++;
                $display("FAIL missing_write cycle=%0d actual=no_write required_port=%0d required_addr=%0d",
                         cyc, expq[0].port, expq[0].a);
                void'(expq.pop_front());
            end
        end
    end

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; m_scnt = 0;
        rst_n = 1'b0;
        zero_inputs();
        #3;
        chk("reset_we",       64'(xrf_we),   64'(0));
        chk("reset_sc_ready", 64'(sc_ready), 64'(2'b11));
        chk("reset_rt_ready", 64'(rt_ready), 64'(4'b1111));
        chk("reset_starve",   64'(starve_o), 64'(0));
        #9 rst_n = 1'b1;

        // Single write-back
        set_stim(1, 2'b00);
        st_la[0] = 5'd5; st_ld[0] = 32'hDEADBEEF;
        drive_cycle();
        chk("single_ready", 64'(rt_ready), 64'(4'b1111));
        idle(1, 2'b00);
        chk("single_we",   64'(xrf_we),          64'(2'b01));
        chk("single_addr", 64'(xrf_waddr[AW-1:0]), 64'(5));
        chk("single_data", 64'(xrf_wdata[XL-1:0]), 64'(32'hDEADBEEF));

        // Burst ordering
        set_stim(4, 2'b00);
        for (int i = 0; i < NRT; i++) st_la[i] = AW'(i + 1);
        drive_cycle();
        idle(1, 2'b00);
        chk("burst_t1_a0", 64'(xrf_waddr[0 +: AW]),  64'(1));
        chk("burst_t1_a1", 64'(xrf_waddr[AW +: AW]), 64'(2));
        idle(1, 2'b00);
        chk("burst_t2_a0", 64'(xrf_waddr[0 +: AW]),  64'(3));
        chk("burst_t2_a1", 64'(xrf_waddr[AW +: AW]), 64'(4));
        idle(1, 2'b00);
        chk("burst_empty_we", 64'(xrf_we), 64'(0));

        // Shared port
        set_stim(2, 2'b00);
        st_la[0] = 5'd10; st_la[1] = 5'd11;
        drive_cycle();
        set_stim(0, 2'b01);
        st_sa[0] = 5'd20;
        drive_cycle();
        chk("shared_we",    64'(xrf_we),             64'(2'b11));
        chk("shared_a0",    64'(xrf_waddr[0 +: AW]),  64'(20));
        chk("shared_a1",    64'(xrf_waddr[AW +: AW]), 64'(10));
        set_stim(0, 2'b01);
        drive_cycle();
        chk("shared_next_a1", 64'(xrf_waddr[AW +: AW]), 64'(11));

        // Starvation
        set_stim(1, 2'b11);
        st_la[0] = 5'd7;
        drive_cycle();
        for (int j = 0; j < LIMIT; j++) begin
            idle(1, 2'b11);
            chk("starve_pre", 64'(starve_o), 64'(0));
        end
        idle(1, 2'b11);
        chk("starve_on",       64'(starve_o), 64'(1));
        chk("starve_sc_ready", 64'(sc_ready), 64'(0));
        chk("starve_we",       64'(xrf_we),   64'(2'b01));
        chk("starve_addr",     64'(xrf_waddr[0 +: AW]), 64'(7));
        idle(1, 2'b11);
        chk("starve_off",      64'(starve_o), 64'(0));
        chk("starve_off_rdy",  64'(sc_ready), 64'(2'b11));

        // Full / backpressure
        set_stim(4, 2'b11); drive_cycle();
        set_stim(4, 2'b11); drive_cycle();
        idle(1, 2'b11);
        chk("full_ready", 64'(rt_ready), 64'(0));
        idle(3, 2'b11);
        set_stim(2, 2'b00); drive_cycle();
        chk("cnt6_ready", 64'(rt_ready), 64'(4'b0011));
        set_stim(2, 2'b00); drive_cycle();
        chk("cnt6_hold_ready", 64'(rt_ready), 64'(4'b0011));
        idle(4, 2'b00);

        // Reset mid-burst
        set_stim(4, 2'b11); drive_cycle();
        set_stim(1, 2'b11); drive_cycle();
        idle(1, 2'b11);
        chk("cnt5_ready", 64'(rt_ready), 64'(4'b0111));
        @(negedge clk);
        #1;
        zero_inputs();
        rst_n = 1'b0;
        #1;
        chk("midrst_we",    64'(xrf_we),   64'(0));
        chk("midrst_ready", 64'(rt_ready), 64'(4'b1111));
        chk("midrst_starve", 64'(starve_o), 64'(0));
        mq.delete();
        m_scnt = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        idle(3, 2'b00);
        chk("post_rst_we", 64'(xrf_we), 64'(0));

        // Random traffic
        repeat (400) begin
            set_stim($urandom_range(0, NRT), NWP'($urandom_range(0, 3)));
            drive_cycle();
        end
        idle(10, 2'b00);

        @(negedge clk);
        #1;
        chk("final_expq_empty", 64'(expq.size()), 64'(0));
        chk("final_ready",      64'(rt_ready),    64'(4'b1111));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
